// File: rtl/aib_sr_ms_frame_ctrl_if.sv
// Sideband control shift-register bus between the master sequencer and its environment.
// master: sequencer side (serial MS-to-SL out, SL-to-MS in, parallel rx word out).
// slave : environment side (aib_sm control word, serial retimed SL data, status in).
interface aib_sr_ms_frame_ctrl_if #(
    parameter int MS_FRAME_BITS = 81,
    parameter int SL_FRAME_BITS = 73,
    parameter int CNT_W         = 16
);
    logic                     enable;
    logic [MS_FRAME_BITS-1:0] tx_data;
    logic                     sr_ms_data_out;
    logic                     sr_ms_clk_en;
    logic                     sr_ms_load_out;
    logic                     sr_sl_data_in;
    logic [SL_FRAME_BITS-1:0] rx_data;
    logic                     rx_valid;
    logic                     busy;
    logic [CNT_W-1:0]         frame_cnt;

    modport master (
        input  enable,
        input  tx_data,
        input  sr_sl_data_in,
        output sr_ms_data_out,
        output sr_ms_clk_en,
        output sr_ms_load_out,
        output rx_data,
        output rx_valid,
        output busy,
        output frame_cnt
    );

    modport slave (
        output enable,
        output tx_data,
        output sr_sl_data_in,
        input  sr_ms_data_out,
        input  sr_ms_clk_en,
        input  sr_ms_load_out,
        input  rx_data,
        input  rx_valid,
        input  busy,
        input  frame_cnt
    );
endinterface

// File: rtl/aib_sr_ms_frame_ctrl.sv
// AIB sideband control shift-register master sequencer (osc_clk domain).
// Frames tx_data MSB-first onto sr_ms_data_out with clk_en/load strobes and
// captures the returning SL-to-MS frame into rx_data.
// Ports: osc_clk, reset_n (async, active low), bus (master modport:
//   enable, tx_data, sr_sl_data_in in; sr_ms_data_out, sr_ms_clk_en,
//   sr_ms_load_out, rx_data, rx_valid, busy, frame_cnt out).
// Optional: define AIB_SR_RX_DEBOUNCE_EN to accept an RX frame only when it
//   matches the previously completed frame.
module aib_sr_ms_frame_ctrl #(
    parameter int MS_FRAME_BITS = 81,
    parameter int SL_FRAME_BITS = 73,
    parameter int GAP_CYCLES    = 2,
    parameter int CNT_W         = 16
) (
    input logic                    osc_clk,
    input logic                    reset_n,
    aib_sr_ms_frame_ctrl_if.master bus
);
    localparam int BW = $clog2(MS_FRAME_BITS + 1);
    localparam int GW = $clog2(GAP_CYCLES + 2);

    localparam logic [BW-1:0] LAST_K  = BW'(MS_FRAME_BITS - 1);
    localparam logic [BW-1:0] SL_K    = BW'(SL_FRAME_BITS);
    localparam logic [GW-1:0] GAP_END = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t                   state;
    logic [BW-1:0]            bit_cnt;
    logic [GW-1:0]            gap_cnt;
    logic [MS_FRAME_BITS-1:0] tx_shift;
    logic [SL_FRAME_BITS-1:0] rx_shift;
    logic [MS_FRAME_BITS-1:0] tx_next;
    logic [SL_FRAME_BITS-1:0] rx_next;

    logic                     data_out_q;
    logic                     clk_en_q;
    logic                     load_q;
    logic [SL_FRAME_BITS-1:0] rx_data_q;
    logic                     rx_valid_q;
    logic                     busy_q;
    logic [CNT_W-1:0]         frame_cnt_q;

`ifdef AIB_SR_RX_DEBOUNCE_EN
    logic [SL_FRAME_BITS-1:0] last_q;
`endif

    // rx_next is the RX word as it stands at the end of the current cycle;
    // bits past the SL frame length are not captured.
    always_comb begin
        tx_next = tx_shift << 1;
        rx_next = rx_shift;
        if (state == SHIFT && bit_cnt < SL_K) begin
            rx_next    = rx_shift << 1;
            rx_next[0] = bus.sr_sl_data_in;
        end
    end

    // Serial outputs are registered one cycle ahead: the value for SHIFT k is
    // computed at the end of LOAD / SHIFT k-1.
    always_ff @(posedge osc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            data_out_q  <= 1'b0;
            clk_en_q    <= 1'b0;
            load_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
`ifdef AIB_SR_RX_DEBOUNCE_EN
            last_q      <= '0;
`endif
        end else begin
            rx_valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.enable) begin
                        state  <= LOAD;
                        busy_q <= 1'b1;
                    end
                end
                LOAD: begin
                    tx_shift   <= bus.tx_data;
                    bit_cnt    <= '0;
                    data_out_q <= bus.tx_data[MS_FRAME_BITS-1];
                    clk_en_q   <= 1'b1;
                    load_q     <= (MS_FRAME_BITS == 1);
                    state      <= SHIFT;
                end
                SHIFT: begin
                    tx_shift <= tx_next;
                    rx_shift <= rx_next;
                    bit_cnt  <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_K) begin
                        data_out_q  <= 1'b0;
                        clk_en_q    <= 1'b0;
                        load_q      <= 1'b0;
                        frame_cnt_q <= frame_cnt_q + 1'b1;
`ifdef AIB_SR_RX_DEBOUNCE_EN
                        last_q <= rx_next;
                        if (rx_next == last_q) begin
                            rx_data_q  <= rx_next;
                            rx_valid_q <= 1'b1;
                        end
`else
                        rx_data_q  <= rx_next;
                        rx_valid_q <= 1'b1;
`endif
                        gap_cnt <= '0;
                        if (GAP_CYCLES != 0) begin
                            state <= GAP;
                        end else if (bus.enable) begin
                            state <= LOAD;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        data_out_q <= tx_next[MS_FRAME_BITS-1];
                        load_q     <= (bit_cnt + 1'b1 == LAST_K);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_END) begin
                        state  <= bus.enable ? LOAD : IDLE;
                        busy_q <= bus.enable;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sr_ms_data_out = data_out_q;
    assign bus.sr_ms_clk_en   = clk_en_q;
    assign bus.sr_ms_load_out = load_q;
    assign bus.rx_data        = rx_data_q;
    assign bus.rx_valid       = rx_valid_q;
    assign bus.busy           = busy_q;
    assign bus.frame_cnt      = frame_cnt_q;
endmodule
